// File: rtl/tlb_ctrl.sv
// tlb_ctrl: sequencer for the dual-search-port TLB.
//   Runs one CP0 TLB instruction (TLBP/TLBR/TLBWI/TLBWR) at a time via an
//   op valid/ready handshake and returns results through resp valid/ready.
//   Search port 1 is shared: the data-memory lookup path owns it in every
//   state except PROBE. Also holds the Wired and Random registers.
// Ports:
//   clk/resetn              clock, async active-low reset
//   op_*                    instruction request + latched CP0 operands
//   wired_wr/wired_in       Wired register write
//   random_out              current Random value
//   resp_*                  registered results, held until overwritten
//   dm_req_*/dm_gnt         data-side lookup request/grant on port 1
//   tlb_s1_*                TLB search port 1
//   tlb_wr/tlb_w_*          TLB write port
//   tlb_r_*                 TLB read port
module tlb_ctrl #(
  parameter int TLB_NUM = 16,
  parameter int IDX_W   = $clog2(TLB_NUM)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op_code,
  input  logic [26:0]      entryhi_in,
  input  logic [25:0]      entrylo0_in,
  input  logic [25:0]      entrylo1_in,
  input  logic [IDX_W-1:0] index_in,
  input  logic             wired_wr,
  input  logic [IDX_W-1:0] wired_in,
  output logic [IDX_W-1:0] random_out,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [1:0]       resp_op,
  output logic             resp_found,
  output logic [IDX_W-1:0] resp_index,
  output logic [26:0]      resp_entryhi,
  output logic [25:0]      resp_entrylo0,
  output logic [25:0]      resp_entrylo1,
  input  logic             dm_req_valid,
  input  logic [18:0]      dm_req_vpn2,
  input  logic             dm_req_odd,
  output logic             dm_gnt,
  output logic [18:0]      tlb_s1_vpn2,
  output logic             tlb_s1_odd_page,
  output logic [7:0]       tlb_s1_asid,
  input  logic             tlb_s1_found,
  input  logic [IDX_W-1:0] tlb_s1_index,
  output logic             tlb_wr,
  output logic [IDX_W-1:0] tlb_w_index,
  output logic [26:0]      tlb_w_entryhi,
  output logic             tlb_w_g,
  output logic [24:0]      tlb_w_lo0,
  output logic [24:0]      tlb_w_lo1,
  output logic [IDX_W-1:0] tlb_r_index,
  input  logic [26:0]      tlb_r_entryhi,
  input  logic             tlb_r_g,
  input  logic [24:0]      tlb_r_lo0,
  input  logic [24:0]      tlb_r_lo1
);

  typedef enum logic [2:0] {IDLE, PROBE, READ, WRITE, DONE} state_e;

  localparam logic [1:0]       OP_TLBP  = 2'd0;
  localparam logic [1:0]       OP_TLBR  = 2'd1;
  localparam logic [1:0]       OP_TLBWR = 2'd3;
  localparam logic [IDX_W-1:0] RND_MAX  = IDX_W'(TLB_NUM - 1);

  state_e           state_q;
  logic [1:0]       op_q;
  logic [26:0]      ehi_q;
  logic [25:0]      lo0_q, lo1_q;
  logic [IDX_W-1:0] idx_q;
  logic             tlb_wr_q, resp_valid_q, resp_found_q;
  logic [1:0]       resp_op_q;
  logic [IDX_W-1:0] resp_index_q;
  logic [26:0]      resp_ehi_q;
  logic [25:0]      resp_lo0_q, resp_lo1_q;
  logic [IDX_W-1:0] random_q, random_d, wired_q;

  assign op_ready      = (state_q == IDLE);
  assign resp_valid    = resp_valid_q;
  assign resp_op       = resp_op_q;
  assign resp_found    = resp_found_q;
  assign resp_index    = resp_index_q;
  assign resp_entryhi  = resp_ehi_q;
  assign resp_entrylo0 = resp_lo0_q;
  assign resp_entrylo1 = resp_lo1_q;
  assign random_out    = random_q;

  assign tlb_wr        = tlb_wr_q;
  assign tlb_w_index   = idx_q;
  assign tlb_w_entryhi = ehi_q;
  assign tlb_w_g       = lo0_q[0] & lo1_q[0];
  assign tlb_w_lo0     = lo0_q[25:1];
  assign tlb_w_lo1     = lo1_q[25:1];
  assign tlb_r_index   = idx_q;

  // Port 1 belongs to the data side except during the single PROBE cycle.
  assign dm_gnt = dm_req_valid & (state_q != PROBE);
  always_comb begin
    tlb_s1_vpn2     = dm_req_vpn2;
    tlb_s1_odd_page = dm_req_odd;
    tlb_s1_asid     = entryhi_in[7:0];
    if (state_q == PROBE) begin
      tlb_s1_vpn2     = ehi_q[26:8];
      tlb_s1_odd_page = 1'b0;
      tlb_s1_asid     = ehi_q[7:0];
    end
  end

  // Random wraps back to the top once it has reached the wired floor.
  assign random_d = (random_q <= wired_q) ? RND_MAX : random_q - IDX_W'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      random_q <= RND_MAX;
      wired_q  <= '0;
    end else if (wired_wr) begin
      random_q <= RND_MAX;
      wired_q  <= wired_in;
    end else begin
      random_q <= random_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      op_q         <= '0;
      ehi_q        <= '0;
      lo0_q        <= '0;
      lo1_q        <= '0;
      idx_q        <= '0;
      tlb_wr_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_op_q    <= '0;
      resp_found_q <= 1'b0;
      resp_index_q <= '0;
      resp_ehi_q   <= '0;
      resp_lo0_q   <= '0;
      resp_lo1_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (op_valid) begin
          op_q  <= op_code;
          ehi_q <= entryhi_in;
          lo0_q <= entrylo0_in;
          lo1_q <= entrylo1_in;
          // TLBWR takes Random as seen this cycle, before any wired_wr reload.
          idx_q <= (op_code == OP_TLBWR) ? random_q : index_in;
          case (op_code)
            OP_TLBP: state_q <= PROBE;
            OP_TLBR: state_q <= READ;
            default: begin
              state_q  <= WRITE;
              tlb_wr_q <= 1'b1;  // registered so it is high exactly in WRITE
            end
          endcase
        end
        PROBE: begin
          resp_found_q <= tlb_s1_found;
          resp_index_q <= tlb_s1_found ? tlb_s1_index : '0;
          resp_op_q    <= op_q;
          resp_valid_q <= 1'b1;
          state_q      <= DONE;
        end
        READ: begin
          resp_ehi_q   <= tlb_r_entryhi;
          resp_lo0_q   <= {tlb_r_lo0, tlb_r_g};
          resp_lo1_q   <= {tlb_r_lo1, tlb_r_g};
          resp_op_q    <= op_q;
          resp_valid_q <= 1'b1;
          state_q      <= DONE;
        end
        WRITE: begin
          tlb_wr_q     <= 1'b0;
          resp_op_q    <= op_q;
          resp_valid_q <= 1'b1;
          state_q      <= DONE;
        end
        DONE: if (resp_ready) begin
          resp_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_ctrl.sv
// Bench for tlb_ctrl: small TLB array model on the TLB ports, scoreboard of
// expected responses pushed at op issue and popped on resp handshake, plus
// cycle-exact checks of write pulse, port-1 sharing, Random and reset.
module tb_tlb_ctrl;
  localparam int N = 16;
  localparam int W = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          op_valid, op_ready;
  logic [1:0]    op_code;
  logic [26:0]   entryhi_in;
  logic [25:0]   entrylo0_in, entrylo1_in;
  logic [W-1:0]  index_in;
  logic          wired_wr;
  logic [W-1:0]  wired_in, random_out;
  logic          resp_valid, resp_ready, resp_found;
  logic [1:0]    resp_op;
  logic [W-1:0]  resp_index;
  logic [26:0]   resp_entryhi;
  logic [25:0]   resp_entrylo0, resp_entrylo1;
  logic          dm_req_valid, dm_req_odd, dm_gnt;
  logic [18:0]   dm_req_vpn2, tlb_s1_vpn2;
  logic          tlb_s1_odd_page;
  logic [7:0]    tlb_s1_asid;
  logic          tlb_s1_found;
  logic [W-1:0]  tlb_s1_index;
  logic          tlb_wr, tlb_w_g;
  logic [W-1:0]  tlb_w_index, tlb_r_index;
  logic [26:0]   tlb_w_entryhi, tlb_r_entryhi;
  logic [24:0]   tlb_w_lo0, tlb_w_lo1, tlb_r_lo0, tlb_r_lo1;
  logic          tlb_r_g;

  tlb_ctrl #(.TLB_NUM(N)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .entryhi_in(entryhi_in), .entrylo0_in(entrylo0_in),
    .entrylo1_in(entrylo1_in), .index_in(index_in), .wired_wr(wired_wr),
    .wired_in(wired_in), .random_out(random_out), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_op(resp_op), .resp_found(resp_found),
    .resp_index(resp_index), .resp_entryhi(resp_entryhi),
    .resp_entrylo0(resp_entrylo0), .resp_entrylo1(resp_entrylo1),
    .dm_req_valid(dm_req_valid), .dm_req_vpn2(dm_req_vpn2),
    .dm_req_odd(dm_req_odd), .dm_gnt(dm_gnt), .tlb_s1_vpn2(tlb_s1_vpn2),
    .tlb_s1_odd_page(tlb_s1_odd_page), .tlb_s1_asid(tlb_s1_asid),
    .tlb_s1_found(tlb_s1_found), .tlb_s1_index(tlb_s1_index),
    .tlb_wr(tlb_wr), .tlb_w_index(tlb_w_index), .tlb_w_entryhi(tlb_w_entryhi),
    .tlb_w_g(tlb_w_g), .tlb_w_lo0(tlb_w_lo0), .tlb_w_lo1(tlb_w_lo1),
    .tlb_r_index(tlb_r_index), .tlb_r_entryhi(tlb_r_entryhi),
    .tlb_r_g(tlb_r_g), .tlb_r_lo0(tlb_r_lo0), .tlb_r_lo1(tlb_r_lo1)
  );

  always #5 clk = ~clk;

  // ---------------- TLB array model ----------------
  logic          init;
  logic [26:0]   m_ehi [N];
  logic          m_g   [N];
  logic          m_v   [N];
  logic [24:0]   m_lo0 [N];
  logic [24:0]   m_lo1 [N];
  int            wcnt;

  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < N; i++) begin
        m_v[i] <= 1'b0; m_ehi[i] <= '0; m_g[i] <= 1'b0; m_lo0[i] <= '0; m_lo1[i] <= '0;
      end
      wcnt <= 0;
    end else if (tlb_wr) begin
      m_v[tlb_w_index]   <= 1'b1;
      m_ehi[tlb_w_index] <= tlb_w_entryhi;
      m_g[tlb_w_index]   <= tlb_w_g;
      m_lo0[tlb_w_index] <= tlb_w_lo0;
      m_lo1[tlb_w_index] <= tlb_w_lo1;
      wcnt <= wcnt + 1;
    end
  end

  always_comb begin
    tlb_s1_found = 1'b0;
    tlb_s1_index = '0;
    for (int i = 0; i < N; i++)
      if (m_v[i] && m_ehi[i][26:8] == tlb_s1_vpn2 && (m_g[i] || m_ehi[i][7:0] == tlb_s1_asid)) begin
        tlb_s1_found = 1'b1;
        tlb_s1_index = W'(i);
      end
  end

  assign tlb_r_entryhi = m_ehi[tlb_r_index];
  assign tlb_r_g       = m_g[tlb_r_index];
  assign tlb_r_lo0     = m_lo0[tlb_r_index];
  assign tlb_r_lo1     = m_lo1[tlb_r_index];

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp_v);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic        found;
    logic [W-1:0] idx;
    logic [26:0] ehi;
    logic [25:0] lo0;
    logic [25:0] lo1;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  function automatic exp_t mk(input logic [1:0] op, input logic f, input logic [W-1:0] ix,
                              input logic [26:0] eh, input logic [25:0] l0, input logic [25:0] l1);
    exp_t e;
    e.op = op; e.found = f; e.idx = ix; e.ehi = eh; e.lo0 = l0; e.lo1 = l1;
    return e;
  endfunction

  always @(negedge clk) begin
    if (resetn && resp_valid && resp_ready) begin
      if (sbq.size() == 0) chk("sb_unexpected_resp", 1, 0);
      else begin
        mon_e = sbq.pop_front();
        chk("resp_op", resp_op, mon_e.op);
        if (mon_e.op == 2'd0) begin
          chk("probe_found", resp_found, mon_e.found);
          chk("probe_index", resp_index, mon_e.idx);
        end else if (mon_e.op == 2'd1) begin
          chk("read_ehi", resp_entryhi, mon_e.ehi);
          chk("read_lo0", resp_entrylo0, mon_e.lo0);
          chk("read_lo1", resp_entrylo1, mon_e.lo1);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] acc_rnd;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!op_ready && n < 50) begin tick(); n++; end
    if (!op_ready) chk("op_ready_timeout", 0, 1);
  endtask

  // Called just after a rising edge; returns just after the accept edge.
  task automatic do_op(input logic [1:0] code, input logic [26:0] eh, input logic [25:0] l0,
                       input logic [25:0] l1, input logic [W-1:0] ix, input exp_t e);
    wait_ready();
    if (!op_ready) return;
    op_valid = 1'b1; op_code = code; entryhi_in = eh;
    entrylo0_in = l0; entrylo1_in = l1; index_in = ix;
    acc_rnd = random_out;
    sbq.push_back(e);
    tick();
    op_valid = 1'b0;
  endtask

  localparam logic [26:0] EHI_A = {19'h12345, 8'h3A};
  localparam logic [25:0] LO0_A = {20'hABCDE, 3'd3, 1'b1, 1'b1, 1'b1};
  localparam logic [25:0] LO1_A = {20'h13579, 3'd2, 1'b0, 1'b1, 1'b1};
  localparam logic [26:0] EHI_B = {19'h0ABCD, 8'h11};
  localparam logic [25:0] LO0_B = {20'h0F0F0, 3'd1, 1'b1, 1'b0, 1'b1};
  localparam logic [25:0] LO1_B = {20'h00AA5, 3'd0, 1'b0, 1'b1, 1'b0};
  localparam logic [26:0] EHI_C = {19'h70000, 8'h01};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    logic [W-1:0] pre;
    resetn = 1'b0; init = 1'b1;
    op_valid = 0; op_code = 0; entryhi_in = 0; entrylo0_in = 0; entrylo1_in = 0;
    index_in = 0; wired_wr = 0; wired_in = 0; resp_ready = 1'b1;
    dm_req_valid = 0; dm_req_vpn2 = 0; dm_req_odd = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_op_ready", op_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_tlb_wr", tlb_wr, 0);
    chk("rst_random", random_out, 15);
    chk("rst_resp_index", resp_index, 0);
    tick();
    resetn = 1'b1; init = 1'b0;
    tick();

    // TLBWI idx 5: one-cycle write at T+1, response at T+2
    w0 = wcnt;
    do_op(2'd2, EHI_A, LO0_A, LO1_A, 4'd5, mk(2'd2, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("wi_wr_t1", tlb_wr, 1);
    chk("wi_windex", tlb_w_index, 5);
    chk("wi_wg", tlb_w_g, 1);
    chk("wi_wehi", tlb_w_entryhi, EHI_A);
    chk("wi_wlo0", tlb_w_lo0, LO0_A[25:1]);
    chk("wi_rv_t1", resp_valid, 0);
    @(negedge clk);
    chk("wi_wr_t2", tlb_wr, 0);
    chk("wi_rv_t2", resp_valid, 1);
    chk("wi_wcount", wcnt - w0, 1);
    tick();

    // second entry with mismatched G bits -> entry G = 0
    do_op(2'd2, EHI_B, LO0_B, LO1_B, 4'd7, mk(2'd2, 0, 0, 0, 0, 0));

    // probes: global hit, miss after hit, asid miss, asid hit
    do_op(2'd0, {19'h12345, 8'h07}, 0, 0, 0, mk(2'd0, 1, 5, 0, 0, 0));
    do_op(2'd0, {19'h00001, 8'h07}, 0, 0, 0, mk(2'd0, 0, 0, 0, 0, 0));
    do_op(2'd0, {19'h0ABCD, 8'h22}, 0, 0, 0, mk(2'd0, 0, 0, 0, 0, 0));
    do_op(2'd0, {19'h0ABCD, 8'h11}, 0, 0, 0, mk(2'd0, 1, 7, 0, 0, 0));

    // reads
    do_op(2'd1, 0, 0, 0, 4'd5, mk(2'd1, 0, 0, EHI_A, {LO0_A[25:1], 1'b1}, {LO1_A[25:1], 1'b1}));
    do_op(2'd1, 0, 0, 0, 4'd7, mk(2'd1, 0, 0, EHI_B, {LO0_B[25:1], 1'b0}, {LO1_B[25:1], 1'b0}));

    // port-1 sharing during a TLBP
    wait_ready();
    dm_req_valid = 1'b1; dm_req_vpn2 = 19'h55555; dm_req_odd = 1'b1;
    do_op(2'd0, {19'h12345, 8'h07}, 0, 0, 0, mk(2'd0, 1, 5, 0, 0, 0));
    entryhi_in = {19'h0, 8'h5A};
    @(negedge clk);
    chk("probe_gnt", dm_gnt, 0);
    chk("probe_s1_vpn2", tlb_s1_vpn2, 19'h12345);
    chk("probe_s1_odd", tlb_s1_odd_page, 0);
    chk("probe_s1_asid", tlb_s1_asid, 8'h07);
    @(negedge clk);
    chk("done_gnt", dm_gnt, 1);
    chk("done_s1_vpn2", tlb_s1_vpn2, 19'h55555);
    chk("done_s1_odd", tlb_s1_odd_page, 1);
    chk("done_s1_asid", tlb_s1_asid, 8'h5A);
    tick();
    dm_req_valid = 1'b0;

    // back-pressure on the response
    resp_ready = 1'b0;
    do_op(2'd1, 0, 0, 0, 4'd5, mk(2'd1, 0, 0, EHI_A, {LO0_A[25:1], 1'b1}, {LO1_A[25:1], 1'b1}));
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_resp_valid", resp_valid, 1);
      chk("stall_op_ready", op_ready, 0);
    end
    tick();
    resp_ready = 1'b1;
    wait_ready();

    // Wired = 4: Random cycles 15..4
    wired_wr = 1'b1; wired_in = 4'd4;
    tick();
    wired_wr = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      chk("random_seq", random_out, 15 - (k % 12));
    end
    tick();

    // TLBWR uses Random from its accept cycle
    do_op(2'd3, EHI_C, LO0_A, LO1_A, 4'd0, mk(2'd3, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("wr_pulse", tlb_wr, 1);
    chk("wr_index", tlb_w_index, acc_rnd);
    chk("wr_index_range", (acc_rnd >= 4) ? 1 : 0, 1);
    tick();

    // TLBWR coinciding with wired_wr takes the pre-update Random
    wait_ready();
    if (random_out == 4'd15) tick();
    pre = random_out;
    wired_wr = 1'b1; wired_in = 4'd2;
    do_op(2'd3, EHI_C, LO0_A, LO1_A, 4'd0, mk(2'd3, 0, 0, 0, 0, 0));
    wired_wr = 1'b0;
    @(negedge clk);
    chk("wrw_pulse", tlb_wr, 1);
    chk("wrw_index", tlb_w_index, pre);
    chk("wrw_random_reload", random_out, 15);
    tick();
    wait_ready();

    // reset pulse over the accept cycle of a TLBWI
    op_valid = 1'b1; op_code = 2'd2; index_in = 4'd3; entryhi_in = EHI_B;
    resetn = 1'b0;
    @(negedge clk);
    chk("rst2_random", random_out, 15);
    chk("rst2_resp_valid", resp_valid, 0);
    tick();
    resetn = 1'b1; op_valid = 1'b0;
    w0 = wcnt;
    @(negedge clk);
    chk("rst2_op_ready", op_ready, 1);
    chk("rst2_random_hold", random_out, 15);
    chk("rst2_found", resp_found, 0);
    chk("rst2_ehi", resp_entryhi, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst2_no_wr", tlb_wr, 0);
      chk("rst2_no_resp", resp_valid, 0);
    end
    chk("rst2_wcount", wcnt - w0, 0);
    chk("sb_left", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
